// File: rtl/mips_mmio_pkg.sv
// mips_mmio_pkg -- shared constants for the memory-mapped I/O window.
// Offsets are addr[6:0] inside the 128-word window. The upper three offset
// bits select the register group and the lower four bits select the channel.
package mips_mmio_pkg;

  localparam logic [6:0] OFS_OUT  = 7'h00;
  localparam logic [6:0] OFS_SET  = 7'h10;
  localparam logic [6:0] OFS_CLR  = 7'h20;
  localparam logic [6:0] OFS_TGL  = 7'h30;
  localparam logic [6:0] OFS_IN   = 7'h40;
  localparam logic [6:0] OFS_EDGE = 7'h50;
  localparam logic [6:0] OFS_IEN  = 7'h60;

  // Returns the group-select field of an offset.
  function automatic logic [2:0] ofs_grp(input logic [6:0] ofs);
    return ofs[6:4];
  endfunction

endpackage

// File: rtl/mips_mmio_if.sv
// mips_mmio_if -- core-side bus between the CPU datapath and the I/O window.
//   addr  : word address (ALU result)     wdata : store data
//   we    : store strobe                  hit   : addr lies inside the window
//   rdata : combinational read data, 0 when hit=0
// Handshake: there is no valid/ready pair. A store is one cycle with we=1,
// and it commits at the rising clk edge when hit=1. Reads are combinational
// from addr and are always accepted. The slave never stalls the master.
interface mips_mmio_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              hit;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wdata, output we, input hit, input rdata);
  modport slave  (input addr, input wdata, input we, output hit, output rdata);
endinterface

// File: rtl/mips_mmio_sync_edge.sv
// sync_edge -- 2-flop synchroniser plus sticky rising-edge flags for one
// input channel.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_async    : raw external input bits
//   i_clr      : write-1-to-clear mask for the edge flags (one cycle)
//   o_sync     : synchronised input
//   o_edge     : sticky edge flags
module sync_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      // The set term is ORed in after the clear, so a new edge beats a
      // simultaneous W1C of the same bit.
      r_edge <= (r_edge & ~i_clr) | (r_sync & ~r_prev);
    end
  end

  assign o_sync = r_sync;
  assign o_edge = r_edge;

endmodule

// File: rtl/mips_mmio.sv
// mips_mmio -- 128-word memory-mapped I/O window for a small MIPS core.
// It provides output registers with SET/CLR/TGL aliases, synchronised inputs
// with sticky edge flags, and an interrupt enable mask.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mips_mmio_if slave (addr, wdata, we -> hit, rdata)
//   in_data    : asynchronous inputs, channel j in slice j (IN_W bits each)
//   out_data   : output registers, channel i in slice i (DATA_W bits each)
//   irq        : OR of edge flags that have their enable bit set
module mips_mmio
  import mips_mmio_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BASE    = 32'h80,
  parameter int NUM_OUT = 2,
  parameter int NUM_IN  = 2,
  parameter int IN_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_mmio_if.slave                bus,
  input  logic [NUM_IN*IN_W-1:0]    in_data,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      irq
);

  localparam int IEN_W = NUM_IN * IN_W;
  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE);

  logic [DATA_W-1:0] r_out [NUM_OUT];
  logic [IEN_W-1:0]  r_ien;

  logic [6:0]        w_off;
  logic [2:0]        w_grp;
  logic [3:0]        w_idx;
  logic              w_hit;
  logic              w_wr;
  logic [IN_W-1:0]   w_clr  [NUM_IN];
  logic [IN_W-1:0]   w_sync [NUM_IN];
  logic [IN_W-1:0]   w_edge [NUM_IN];
  logic [IEN_W-1:0]  w_edge_flat;
  logic [DATA_W-1:0] w_rdata;

  assign w_off = bus.addr[6:0];
  assign w_grp = w_off[6:4];
  assign w_idx = w_off[3:0];
  assign w_hit = (bus.addr[ADDR_W-1:7] == L_BASE[ADDR_W-1:7]);
  assign w_wr  = bus.we & w_hit;

  // Per-channel synchroniser and edge detector
  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    assign w_clr[j] = (w_wr && w_grp == ofs_grp(OFS_EDGE) && w_idx == 4'(j))
                      ? bus.wdata[IN_W-1:0] : '0;

    sync_edge #(.W(IN_W)) u_sync_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (in_data[j*IN_W +: IN_W]),
      .i_clr   (w_clr[j]),
      .o_sync  (w_sync[j]),
      .o_edge  (w_edge[j])
    );

    assign w_edge_flat[j*IN_W +: IN_W] = w_edge[j];
  end

  // Output registers and interrupt enable. The operations apply to the
  // registered value each cycle, so consecutive SET/CLR/TGL stores accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
      r_ien <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_idx == 4'(i)) begin
          if (w_grp == ofs_grp(OFS_OUT))      r_out[i] <= bus.wdata;
          else if (w_grp == ofs_grp(OFS_SET)) r_out[i] <= r_out[i] | bus.wdata;
          else if (w_grp == ofs_grp(OFS_CLR)) r_out[i] <= r_out[i] & ~bus.wdata;
          else if (w_grp == ofs_grp(OFS_TGL)) r_out[i] <= r_out[i] ^ bus.wdata;
        end
      end
      if (w_off == OFS_IEN) r_ien <= IEN_W'(bus.wdata);
    end
  end

  // Read mux. Out-of-range channel indices and unmapped offsets fall through to 0.
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      if (w_grp == ofs_grp(OFS_OUT) || w_grp == ofs_grp(OFS_SET) ||
          w_grp == ofs_grp(OFS_CLR) || w_grp == ofs_grp(OFS_TGL)) begin
        for (int i = 0; i < NUM_OUT; i++)
          if (w_idx == 4'(i)) w_rdata = r_out[i];
      end else if (w_grp == ofs_grp(OFS_IN)) begin
        for (int j = 0; j < NUM_IN; j++)
          if (w_idx == 4'(j)) w_rdata = DATA_W'(w_sync[j]);
      end else if (w_grp == ofs_grp(OFS_EDGE)) begin
        for (int j = 0; j < NUM_IN; j++)
          if (w_idx == 4'(j)) w_rdata = DATA_W'(w_edge[j]);
      end else if (w_off == OFS_IEN) begin
        w_rdata = DATA_W'(r_ien);
      end
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign out_data[i*DATA_W +: DATA_W] = r_out[i];
  end

  assign bus.hit   = w_hit;
  assign bus.rdata = w_rdata;
  assign irq       = |(w_edge_flat & r_ien);

endmodule

// File: tb/tb_mips_mmio.sv
// tb_mips_mmio -- directed bench for mips_mmio with default parameters.
module tb_mips_mmio;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [63:0] out_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  mips_mmio_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mmio dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .in_data  (in_data),
    .out_data (out_data),
    .irq      (irq)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers. Each is called just after a falling edge, and a store spans one posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [63:0] exp);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    check(tag, 64'(bus.rdata), exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", out_data, 64'h0);
    check("reset_irq", 64'(irq), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // OUT / SET / CLR / TGL on OUT[0]
    rd("hit_0x80", 32'h80, 64'h0);
    check("hit_flag_0x80", 64'(bus.hit), 64'h1);
    wr(32'h80, 32'h00F0);  rd("out0_wr",  32'h80, 64'h00F0);
    wr(32'h90, 32'h000F);  rd("out0_set", 32'h90, 64'h00FF);
    wr(32'hA0, 32'h0003);  rd("out0_clr", 32'hA0, 64'h00FC);
    wr(32'hB0, 32'h0101);  rd("out0_tgl", 32'hB0, 64'h01FD);
    check("out_data_0", out_data, 64'h0000_0000_0000_01FD);

    // Back-to-back stores on OUT[1] accumulate
    wr(32'h81, 32'h00A0);
    wr(32'h91, 32'h000F);
    wr(32'hA1, 32'h00A0);
    wr(32'hB1, 32'h00FF);
    rd("out1_b2b", 32'hA1, 64'h00F0);
    check("out_data_b2b", out_data, 64'h0000_00F0_0000_01FD);

    // Input synchronisation and edge timing: ch0 0->5, ch1 0->A
    in_data = 8'hA5;
    @(negedge clk);                      // after edge 1
    rd("in0_edge1", 32'hC0, 64'h0);
    @(negedge clk);                      // after edge 2
    rd("in0_edge2",   32'hC0, 64'h5);
    rd("in1_edge2",   32'hC1, 64'hA);
    rd("edge0_edge2", 32'hD0, 64'h0);
    @(negedge clk);                      // after edge 3
    rd("edge0_edge3", 32'hD0, 64'h5);
    rd("edge1_edge3", 32'hD1, 64'hA);
    check("irq_ien0", 64'(irq), 64'h0);

    // Interrupt enable and W1C
    wr(32'hE0, 32'h1);
    rd("ien_rd", 32'hE0, 64'h1);
    check("irq_on", 64'(irq), 64'h1);
    wr(32'hD0, 32'h1);
    rd("edge0_w1c", 32'hD0, 64'h4);
    check("irq_off", 64'(irq), 64'h0);

    // Set wins over a simultaneous clear on bit 2
    in_data = 8'hA0;
    repeat (4) @(negedge clk);
    rd("edge0_sticky", 32'hD0, 64'h4);
    in_data = 8'hA4;
    @(negedge clk);
    @(negedge clk);                      // sync=1 and prev=0: the flag sets at the next edge
    wr(32'hD0, 32'h4);
    rd("edge0_set_wins", 32'hD0, 64'h4);
    wr(32'hD0, 32'h4);
    rd("edge0_clr2", 32'hD0, 64'h0);

    // Unmapped / out-of-range / read-only
    wr(32'h84, 32'h1234);
    rd("oor_out4", 32'h84, 64'h0);
    rd("oor_set4", 32'h94, 64'h0);
    check("oor_out_data", out_data, 64'h0000_00F0_0000_01FD);
    wr(32'hC0, 32'hF);
    rd("in0_ro", 32'hC0, 64'h4);
    rd("edge0_after_in_wr", 32'hD0, 64'h0);
    wr(32'hFF, 32'hFFFF_FFFF);
    rd("unmapped_7f", 32'hFF, 64'h0);
    rd("ien_after_unmapped", 32'hE0, 64'h1);
    rd("unmapped_e1", 32'hE1, 64'h0);
    wr(32'h7F, 32'hFFFF_FFFF);
    rd("miss_7f_rdata", 32'h7F, 64'h0);
    check("miss_7f_hit", 64'(bus.hit), 64'h0);
    rd("miss_00_rdata", 32'h00, 64'h0);
    check("miss_00_hit", 64'(bus.hit), 64'h0);
    check("miss_out_data", out_data, 64'h0000_00F0_0000_01FD);
    wr(32'hE0, 32'hFFFF_FFFF);
    rd("ien_upper_zero", 32'hE0, 64'hFF);

    // Asynchronous reset mid-cycle, including mid-store
    wr(32'h81, 32'hDEAD_BEEF);
    check("out1_beef", out_data, 64'hDEAD_BEEF_0000_01FD);
    bus.addr  = 32'h80;
    bus.wdata = 32'h55;
    bus.we    = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out_data, 64'h0);
    check("async_rst_irq", 64'(irq), 64'h0);
    @(negedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    rd("rst_store_discard", 32'h80, 64'h0);
    rd("rst_ien", 32'hE0, 64'h0);

    // Input held high across reset release: the flag sets 3 edges later
    @(negedge clk);                      // release + 1
    @(negedge clk);                      // release + 2
    rd("rel_in0_e2",   32'hC0, 64'h4);
    rd("rel_edge0_e2", 32'hD0, 64'h0);
    @(negedge clk);                      // release + 3
    rd("rel_edge0_e3", 32'hD0, 64'h4);
    rd("rel_edge1_e3", 32'hD1, 64'hA);
    check("rel_irq", 64'(irq), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
